jtgng_ram_dma: RTL and testbench
================================

Name: jtgng_ram_dma

Overview:
- Bus-master copy engine that drives the address/data/we side of the team's single-port synchronous RAMs.
- Reads a whole source RAM (e.g. CPU object RAM) and writes it word-for-word into a destination buffer RAM (e.g. object line/frame buffer).
- Triggered once per frame at blanking.
- Acquires the source RAM from the CPU with a bus_req/bus_ack handshake, streams 2**aw words with a 2-deep read pipeline, then releases the bus.

Parameters:
- dw, 8, data width of source and destination words
- aw, 9, address width; transfer length is 2**aw words

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state, counters and strobes advance only on clk edges with cen=1
- start  in  1  transfer request, sampled on cen cycles; ignored while busy=1
- bus_req  out  1  request ownership of the source RAM from the CPU
- bus_ack  in  1  CPU grants the source RAM; must stay high while bus_req=1
- src_addr  out  aw  source RAM address
- src_q  in  dw  source RAM read data; valid one cen cycle after src_addr is presented
- dst_addr  out  aw  destination RAM address (registered)
- dst_data  out  dw  destination RAM write data (registered)
- dst_we  out  1  destination write strobe (registered); qualifies one cen cycle
- busy  out  1  high from acceptance of start until the transfer completes
- done  out  1  one-clk pulse on completion

Behaviour:
- Reset, or rst at any point including mid-transfer:
  - state=IDLE.
  - bus_req, dst_we, busy and done are 0.
  - src_addr, dst_addr, dst_data and the counter are 0.
  - No write is issued after the rst edge.
- States: IDLE, REQ, XFER, DRAIN. All transitions occur on cen=1 edges.
- IDLE:
  - start=1 -> REQ, with bus_req<=1, busy<=1, cnt<=0.
- REQ:
  - Wait for bus_ack=1, then go to XFER.
  - src_addr=0 is presented from entry to XFER.
- XFER, each cen cycle:
  - src_addr=cnt, then cnt<=cnt+1.
  - When cnt=2**aw-1 has been presented -> DRAIN.
  - Counter is aw+1 bits wide, so the terminal compare has no wrap-around aliasing.
- Pipeline, with cen cycle k presenting src_addr=a:
  - In cycle k+1, src_q=mem[a].
  - At the end of k+1 the block registers dst_addr<=a, dst_data<=src_q, dst_we<=1.
  - Destination RAM writes during cycle k+2.
  - Latency from address to write strobe is 2 cen cycles, and dst_addr is a delayed copy of src_addr.
  - Writes are back-to-back, one per cen cycle, in ascending address order 0..2**aw-1.
- DRAIN:
  - Runs 2 cen cycles to flush the pipeline.
  - bus_req<=0 after the last source read has been captured, at the end of the first DRAIN cycle.
  - On exit: dst_we<=0, busy<=0, done<=1 for exactly one clk cycle, state IDLE.
- Total busy duration after bus_ack = 2**aw + 2 cen cycles.
- dst_we is 0 in every cen cycle that carries no valid data, including REQ and the first XFER cycle.
- On cen=0 clocks all outputs hold. dst_we may stay high across cen=0 clocks; the destination RAM qualifies writes with cen.
- bus_ack drops during XFER (protocol violation) -> abort:
  - dst_we<=0 on that cen edge; in-flight data is discarded.
  - cnt<=0, state REQ, bus_req stays 1.
  - The transfer restarts from address 0 when bus_ack returns.
- bus_ack dropping in DRAIN is ignored.
- start while busy is ignored; no queuing.
- start coincident with the done pulse is ignored.

Decomposition:
- Shared package (jtgng_pkg):
  - state encoding constants: IDLE=2'd0, REQ=2'd1, XFER=2'd2, DRAIN=2'd3
  - constant DMA_PIPE=2 (read pipeline depth)
- One natural sub-module, jtgng_ram_dma_pipe: the 2-stage address/valid delay line (src address -> dst_addr and dst_we alignment), parameterised by aw.
- Controller FSM and counter live in the top module.
- Bench instantiates two jtgng_ram instances (cen_rd=1) as source and destination.

Test Plan:
- aw=4, source preloaded mem[i]=8'hA0+i, bus_ack tied 1, cen=1, pulse start:
  - first dst_we 3 cycles after start (REQ, then 2-cycle pipe).
  - 16 consecutive writes to dst_addr 0..15 with data A0..AF.
  - done pulses once at cycle 20; busy low afterwards.
- Same with cen toggling 1/0 every clk: identical write sequence; each write held exactly 2 clk; total duration doubled.
- bus_ack delayed 10 cen cycles after bus_req: no dst_we during the wait; then the transfer behaves exactly as in the first scenario.
- bus_ack dropped for 3 cycles after the 5th write:
  - dst_we=0 during the drop.
  - Transfer restarts at dst_addr 0.
  - Destination ends equal to the source; exactly one done pulse.
- rst asserted mid-XFER at cnt=7:
  - the next clk shows bus_req=0, dst_we=0, busy=0, no done.
  - A new start completes a full copy.
- start pulsed repeatedly while busy, and coincident with done: exactly one transfer, one done, no second bus_req.

Source files
------------

// File: rtl/jtgng_pkg.sv
// Shared definitions for the RAM copy engine: controller state encoding and
// the depth of the source-read pipeline.
package jtgng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } dma_state_e;

  localparam int unsigned DMA_PIPE = 2;

endpackage

// File: rtl/jtgng_ram.sv
// Single-port synchronous RAM. With cen_rd set, the read register only
// advances on clock-enabled edges; writes are always qualified by cen.
module jtgng_ram #(
  parameter int unsigned dw     = 8,
  parameter int unsigned aw     = 9,
  parameter bit          cen_rd = 1'b0
) (
  input  logic          clk,
  input  logic          cen,
  input  logic [dw-1:0] data,
  input  logic [aw-1:0] addr,
  input  logic          we,
  output logic [dw-1:0] q
);

  logic [dw-1:0] mem_q [0:(1 << aw) - 1];

  always_ff @(posedge clk) begin
    if (cen && we) mem_q[addr] <= data;
    if (cen || !cen_rd) q <= mem_q[addr];
  end

endmodule

// File: rtl/jtgng_ram_dma_pipe.sv
// Two-stage delay line aligning the presented source address with the data
// the source RAM returns, producing registered destination write signals.
module jtgng_ram_dma_pipe #(
  parameter int unsigned aw = 9,
  parameter int unsigned dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [aw-1:0] in_addr,
  input  logic [dw-1:0] in_data,
  output logic [aw-1:0] out_addr,
  output logic [dw-1:0] out_data,
  output logic          out_we
);

  logic [aw-1:0] addr1_q, addr1_d, out_addr_q, out_addr_d;
  logic [dw-1:0] out_data_q, out_data_d;
  logic          valid1_q, valid1_d, out_we_q, out_we_d;

  always_comb begin
    addr1_d    = addr1_q;
    valid1_d   = valid1_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_we_d   = out_we_q;
    if (cen) begin
      addr1_d  = in_addr;
      valid1_d = in_valid && !flush;
      // A flush drops whatever is in flight, including the word arriving now.
      out_we_d = valid1_q && !flush;
      if (valid1_q && !flush) begin
        out_addr_d = addr1_q;
        out_data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr1_q    <= '0;
      valid1_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_we_q   <= 1'b0;
    end else begin
      addr1_q    <= addr1_d;
      valid1_q   <= valid1_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_we_q   <= out_we_d;
    end
  end

  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign out_we   = out_we_q;

endmodule

// File: rtl/jtgng_ram_dma.sv
// Bus-master copy engine: acquires the source RAM, streams all 2**aw words into
// the destination RAM in ascending order, then releases the bus.
module jtgng_ram_dma #(
  parameter int unsigned dw = 8,
  parameter int unsigned aw = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic [aw-1:0] src_addr,
  input  logic [dw-1:0] src_q,
  output logic [aw-1:0] dst_addr,
  output logic [dw-1:0] dst_data,
  output logic          dst_we,
  output logic          busy,
  output logic          done
);
  import jtgng_pkg::*;

  // Counter is one bit wider than the address so the terminal compares never alias.
  localparam logic [aw:0] CntLast     = (aw + 1)'((1 << aw) - 1);
  localparam logic [aw:0] CntDrainEnd = (aw + 1)'((1 << aw) + DMA_PIPE - 1);

  dma_state_e  state_q, state_d;
  logic [aw:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pipe_valid, pipe_flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_req_d  = bus_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pipe_valid = 1'b0;
    pipe_flush = 1'b0;
    if (cen) begin
      unique case (state_q)
        IDLE: begin
          if (start && !done_q) begin
            state_d   = REQ;
            bus_req_d = 1'b1;
            busy_d    = 1'b1;
            cnt_d     = '0;
          end
        end
        REQ: begin
          if (bus_ack) state_d = XFER;
        end
        XFER: begin
          if (!bus_ack) begin
            // CPU took the bus back: discard the partial copy and start over.
            pipe_flush = 1'b1;
            cnt_d      = '0;
            state_d    = REQ;
          end else begin
            pipe_valid = 1'b1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CntLast) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == CntDrainEnd) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            bus_req_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_req_q <= bus_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign src_addr = cnt_q[aw-1:0];
  assign bus_req  = bus_req_q;
  assign busy     = busy_q;
  assign done     = done_q;

  jtgng_ram_dma_pipe #(
    .aw(aw),
    .dw(dw)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .flush   (pipe_flush),
    .in_valid(pipe_valid),
    .in_addr (src_addr),
    .in_data (src_q),
    .out_addr(dst_addr),
    .out_data(dst_data),
    .out_we  (dst_we)
  );

endmodule

// File: tb/tb_jtgng_ram_dma.sv
// Directed bench for jtgng_ram_dma copying between two jtgng_ram instances,
// with a write monitor and hand-computed timing expectations.
module tb_jtgng_ram_dma;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int N = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, cen, start, bus_ack;
  logic          bus_req, dst_we, busy, done;
  logic [AW-1:0] src_addr, dst_addr;
  logic [DW-1:0] src_q, dst_data, dst_q;
  logic [AW-1:0] cpu_addr, rd_addr, src_ram_addr, dst_ram_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_we, src_ram_we;
  logic          cen_toggle = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state (written only by the monitor processes).
  int            cyc       = 0;
  int            we_clks   = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            req_rises = 0;
  logic          req_prev  = 1'b0;
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  int            wlog_cyc[$];

  assign src_ram_addr = bus_req ? src_addr : cpu_addr;
  assign src_ram_we   = cpu_we & ~bus_req;
  assign dst_ram_addr = dst_we ? dst_addr : rd_addr;

  jtgng_ram #(.dw(DW), .aw(AW), .cen_rd(1'b1)) u_src (
    .clk (clk),
    .cen (cen),
    .data(cpu_data),
    .addr(src_ram_addr),
    .we  (src_ram_we),
    .q   (src_q)
  );

  jtgng_ram #(.dw(DW), .aw(AW), .cen_rd(1'b1)) u_dst (
    .clk (clk),
    .cen (cen),
    .data(dst_data),
    .addr(dst_ram_addr),
    .we  (dst_we),
    .q   (dst_q)
  );

  jtgng_ram_dma #(.dw(DW), .aw(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .start   (start),
    .bus_req (bus_req),
    .bus_ack (bus_ack),
    .src_addr(src_addr),
    .src_q   (src_q),
    .dst_addr(dst_addr),
    .dst_data(dst_data),
    .dst_we  (dst_we),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cen && dst_we) begin
      wlog_addr.push_back(dst_addr);
      wlog_data.push_back(dst_data);
      wlog_cyc.push_back(cyc);
    end
    if (dst_we) we_clks <= we_clks + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= bus_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (cen_toggle) cen = ~cen;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; start = 1'b0; bus_ack = 1'b1;
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; rd_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_checks++; if (dst_we !== 1'b0) begin n_fail++; $display("FAIL reset_dst_we: got %b want 0", dst_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (src_addr !== '0) begin n_fail++; $display("FAIL reset_src_addr: got %0h want 0", src_addr); end
    n_checks++; if (dst_addr !== '0) begin n_fail++; $display("FAIL reset_dst_addr: got %0h want 0", dst_addr); end
    n_checks++; if (dst_data !== '0) begin n_fail++; $display("FAIL reset_dst_data: got %0h want 0", dst_data); end
  endtask

  task automatic test_basic();
    int b, d, w, t0;
    bit ok;
    for (int i = 0; i < N; i++) begin
      cpu_addr = AW'(i); cpu_data = DW'(8'hA0 + i); cpu_we = 1'b1;
      step();
    end
    cpu_we = 1'b0;
    b = wlog_addr.size(); d = done_cnt; w = we_clks;
    start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
    wait_done(d, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
    n_checks++; if (wlog_addr.size() - b != N) begin n_fail++; $display("FAIL basic_wr_count: got %0d want %0d", wlog_addr.size() - b, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wlog_addr[b+i] !== AW'(i) || wlog_data[b+i] !== DW'(8'hA0 + i) || wlog_cyc[b+i] != t0 + 4 + i) begin
        n_fail++;
        $display("FAIL basic_wr[%0d]: got a=%0h d=%0h c=%0d want a=%0h d=%0h c=%0d", i, wlog_addr[b+i], wlog_data[b+i], wlog_cyc[b+i], i, 8'hA0 + i, t0 + 4 + i);
      end
    end
    n_checks++; if (done_cyc != t0 + 20) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc - t0, 20); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d); end
    n_checks++; if (we_clks - w != N) begin n_fail++; $display("FAIL basic_we_clks: got %0d want %0d", we_clks - w, N); end
    n_checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got busy=%b req=%b want 0 0", busy, bus_req); end
  endtask

  task automatic test_cen_toggle();
    int b, d, w, t0;
    bit ok;
    cen_toggle = 1'b1;
    step();
    step();
    b = wlog_addr.size(); d = done_cnt; w = we_clks;
    start = 1'b1; t0 = cyc;
    step();
    step();
    start = 1'b0;
    wait_done(d, 100, ok);
    cen_toggle = 1'b0;
    cen = 1'b1;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cen_timeout: got no done want done"); end
    n_checks++; if (wlog_addr.size() - b != N) begin n_fail++; $display("FAIL cen_wr_count: got %0d want %0d", wlog_addr.size() - b, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wlog_addr[b+i] !== AW'(i) || wlog_data[b+i] !== DW'(8'hA0 + i) || wlog_cyc[b+i] != t0 + 8 + 2 * i) begin
        n_fail++;
        $display("FAIL cen_wr[%0d]: got a=%0h d=%0h c=%0d want a=%0h d=%0h c=%0d", i, wlog_addr[b+i], wlog_data[b+i], wlog_cyc[b+i], i, 8'hA0 + i, t0 + 8 + 2 * i);
      end
    end
    n_checks++; if (we_clks - w != 2 * N) begin n_fail++; $display("FAIL cen_we_clks: got %0d want %0d", we_clks - w, 2 * N); end
    n_checks++; if (done_cyc != t0 + 39) begin n_fail++; $display("FAIL cen_done_cycle: got %0d want %0d", done_cyc - t0, 39); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL cen_done_count: got %0d want 1", done_cnt - d); end
  endtask

  task automatic test_ack_delay();
    int b, d, w, t1;
    bit ok;
    bus_ack = 1'b0;
    b = wlog_addr.size(); d = done_cnt; w = we_clks;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    n_checks++; if (we_clks != w) begin n_fail++; $display("FAIL delay_no_we: got %0d want 0", we_clks - w); end
    n_checks++; if (bus_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL delay_waiting: got req=%b busy=%b want 1 1", bus_req, busy); end
    bus_ack = 1'b1; t1 = cyc;
    wait_done(d, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL delay_timeout: got no done want done"); end
    n_checks++; if (wlog_addr.size() - b != N) begin n_fail++; $display("FAIL delay_wr_count: got %0d want %0d", wlog_addr.size() - b, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wlog_addr[b+i] !== AW'(i) || wlog_data[b+i] !== DW'(8'hA0 + i) || wlog_cyc[b+i] != t1 + 3 + i) begin
        n_fail++;
        $display("FAIL delay_wr[%0d]: got a=%0h d=%0h c=%0d want a=%0h d=%0h c=%0d", i, wlog_addr[b+i], wlog_data[b+i], wlog_cyc[b+i], i, 8'hA0 + i, t1 + 3 + i);
      end
    end
    n_checks++; if (done_cyc != t1 + 19) begin n_fail++; $display("FAIL delay_done_cycle: got %0d want %0d", done_cyc - t1, 19); end
  endtask

  task automatic test_ack_drop();
    int b, d;
    bit ok;
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i); cpu_we = 1'b0;
    end
    b = wlog_addr.size(); d = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (wlog_addr.size() >= b + 5) break;
      step();
    end
    bus_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (dst_we !== 1'b0 || bus_req !== 1'b1) begin n_fail++; $display("FAIL drop_hold[%0d]: got we=%b req=%b want 0 1", k, dst_we, bus_req); end
    end
    bus_ack = 1'b1;
    wait_done(d, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_timeout: got no done want done"); end
    // Six writes land before the abort edge (addr 0..5), then a full restart.
    n_checks++; if (wlog_addr.size() - b != N + 6) begin n_fail++; $display("FAIL drop_wr_count: got %0d want %0d", wlog_addr.size() - b, N + 6); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wlog_addr[b+6+i] !== AW'(i) || wlog_data[b+6+i] !== DW'(8'hA0 + i)) begin
        n_fail++;
        $display("FAIL drop_restart_wr[%0d]: got a=%0h d=%0h want a=%0h d=%0h", i, wlog_addr[b+6+i], wlog_data[b+6+i], i, 8'hA0 + i);
      end
    end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL drop_done_count: got %0d want 1", done_cnt - d); end
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      step();
      n_checks++; if (dst_q !== DW'(8'hA0 + i)) begin n_fail++; $display("FAIL drop_dst_mem[%0d]: got %0h want %0h", i, dst_q, 8'hA0 + i); end
    end
  endtask

  task automatic test_rst_mid();
    int b, d;
    bit ok;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (src_addr == AW'(7)) break;
      step();
    end
    n_checks++; if (src_addr !== AW'(7) || busy !== 1'b1) begin n_fail++; $display("FAIL rst_reach_cnt7: got addr=%0h busy=%b want 7 1", src_addr, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    b = wlog_addr.size(); d = done_cnt;
    n_checks++; if (bus_req !== 1'b0 || dst_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_outputs: got req=%b we=%b busy=%b done=%b want 0 0 0 0", bus_req, dst_we, busy, done);
    end
    n_checks++; if (src_addr !== '0 || dst_addr !== '0 || dst_data !== '0) begin
      n_fail++;
      $display("FAIL rst_regs: got src=%0h dst=%0h data=%0h want 0 0 0", src_addr, dst_addr, dst_data);
    end
    repeat (5) step();
    n_checks++; if (wlog_addr.size() != b || done_cnt != d) begin n_fail++; $display("FAIL rst_quiet: got wr=%0d done=%0d want 0 0", wlog_addr.size() - b, done_cnt - d); end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_restart_timeout: got no done want done"); end
    n_checks++; if (wlog_addr.size() - b != N) begin n_fail++; $display("FAIL rst_restart_count: got %0d want %0d", wlog_addr.size() - b, N); end
    for (int i = 0; i < N; i++) begin
      n_checks++; if (wlog_addr[b+i] !== AW'(i) || wlog_data[b+i] !== DW'(8'hA0 + i)) begin
        n_fail++;
        $display("FAIL rst_restart_wr[%0d]: got a=%0h d=%0h want a=%0h d=%0h", i, wlog_addr[b+i], wlog_data[b+i], i, 8'hA0 + i);
      end
    end
  endtask

  task automatic test_start_busy();
    int b, d, r;
    bit seen;
    b = wlog_addr.size(); d = done_cnt; r = req_rises;
    seen = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      start = ~start;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    n_checks++; if (!seen) begin n_fail++; $display("FAIL busy_timeout: got no done want done"); end
    n_checks++; if (req_rises - r != 1) begin n_fail++; $display("FAIL busy_req_rises: got %0d want 1", req_rises - r); end
    n_checks++; if (done_cnt - d != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d); end
    n_checks++; if (wlog_addr.size() - b != N) begin n_fail++; $display("FAIL busy_wr_count: got %0d want %0d", wlog_addr.size() - b, N); end
    n_checks++; if (busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got busy=%b req=%b want 0 0", busy, bus_req); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cen_toggle();
    test_ack_delay();
    test_ack_drop();
    test_rst_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
